// File: rtl/sync_analyzer_pkg.sv
// Shared state encoding and video line-count thresholds for the sync analyzer.
package sync_analyzer_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int PAL_LINES        = 288;
  localparam int SCANDOUBLE_LINES = 400;
  localparam int PAL_SD_LINES     = 576;

endpackage

// File: rtl/sync_period_counter.sv
// Rising-edge detector plus saturating period/active counters; the last complete period is
// available combinationally on the edge sample and registered afterwards. No backpressure.
module sync_period_counter
  import sync_analyzer_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic         sync,
  input  logic         tick,
  input  logic         qual,
  output logic         rise,
  output logic         sat,
  output logic         sat_hit,
  output logic [W-1:0] period,
  output logic [W-1:0] active,
  output logic         period_vld
);

  localparam logic [W-1:0] MAX    = '1;
  localparam logic [W-1:0] MAX_M1 = MAX - W'(1);

  logic         sync_q;
  logic         started;
  logic         vld_q;
  logic         act_tick;
  logic [W-1:0] cnt;
  logic [W-1:0] act_cnt;
  logic [W-1:0] period_q;
  logic [W-1:0] active_q;

  assign act_tick = tick & qual;
  assign rise     = ce & sync & ~sync_q;
  assign sat      = (cnt == MAX);
  assign sat_hit  = ce & ~rise & tick & (cnt == MAX_M1);

  // The tick on the edge sample closes the period that is ending, not the new one.
  always_comb begin
    period     = period_q;
    active     = active_q;
    period_vld = vld_q;
    if (rise) begin
      period     = cnt + W'(tick);
      active     = act_cnt + W'(act_tick);
      period_vld = started & ~sat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= 1'b0;
      started  <= 1'b0;
      vld_q    <= 1'b0;
      cnt      <= '0;
      act_cnt  <= '0;
      period_q <= '0;
      active_q <= '0;
    end else if (ce) begin
      sync_q <= sync;
      if (rise) begin
        started  <= 1'b1;
        cnt      <= '0;
        act_cnt  <= '0;
        period_q <= period;
        active_q <= active;
        vld_q    <= period_vld;
      end else begin
        if (tick && !sat) cnt <= cnt + W'(1);
        if (act_tick && (act_cnt != MAX)) act_cnt <= act_cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/sync_analyzer.sv
// Video timing analyzer: outputs update one clk after a VSync-rise sample ending a valid frame; no backpressure.
// Define SYNC_ANALYZER_LUMA_EN to build the active-pixel luma peak tracker (luma_peak is 0 otherwise).
module sync_analyzer
  import sync_analyzer_pkg::*;
#(
  parameter int HW          = 10,
  parameter int VW          = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic          HSync,
  input  logic          VSync,
  input  logic          HBlank,
  input  logic          VBlank,
  input  logic [7:0]    video,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_active,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_active,
  output logic          pal,
  output logic          scandouble,
  output logic          locked,
  output logic          frame_done,
  output logic [7:0]    luma_peak
);

  localparam int LCW = $clog2(LOCK_FRAMES + 1);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_FRAMES);

  logic          h_rise, h_sat, h_sat_hit, h_per_vld;
  logic          v_rise, v_sat, v_sat_hit, v_per_vld;
  logic [HW-1:0] h_per, h_act;
  logic [VW-1:0] v_per, v_act;

  sync_period_counter #(.W(HW)) u_h (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce_pix),
    .sync       (HSync),
    .tick       (1'b1),
    .qual       (~HBlank),
    .rise       (h_rise),
    .sat        (h_sat),
    .sat_hit    (h_sat_hit),
    .period     (h_per),
    .active     (h_act),
    .period_vld (h_per_vld)
  );

  sync_period_counter #(.W(VW)) u_v (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce_pix),
    .sync       (VSync),
    .tick       (h_rise),
    .qual       (~VBlank),
    .rise       (v_rise),
    .sat        (v_sat),
    .sat_hit    (v_sat_hit),
    .period     (v_per),
    .active     (v_act),
    .period_vld (v_per_vld)
  );

  state_t         state, state_nxt;
  logic [LCW-1:0] lock_cnt, lock_cnt_nxt;
  logic           frame_bad;
  logic           frame_ok;
  logic           match;
  logic           frame_done_nxt;
  logic           sd_new, pal_new;

  // Any saturation seen since the frame started poisons that frame.
  assign frame_ok = v_rise & v_per_vld & h_per_vld & ~h_sat & ~frame_bad;
  assign match    = (h_per == h_total) && (v_per == v_total);
  assign sd_new   = 32'(v_per) > SCANDOUBLE_LINES;
  assign pal_new  = sd_new ? (32'(v_per) > PAL_SD_LINES) : (32'(v_per) > PAL_LINES);
  assign locked   = (state == LOCKED);

  always_comb begin
    state_nxt      = state;
    lock_cnt_nxt   = lock_cnt;
    frame_done_nxt = 1'b0;
    if (ce_pix) begin
      case (state)
        SEARCH: if (v_rise) state_nxt = MEASURE;
        default: begin
          if (h_sat_hit || v_sat_hit) begin
            lock_cnt_nxt = '0;
            state_nxt    = MEASURE;
          end else if (frame_ok) begin
            frame_done_nxt = 1'b1;
            if (match) lock_cnt_nxt = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LCW'(1);
            else       lock_cnt_nxt = '0;
            state_nxt = (lock_cnt_nxt >= LOCK_MAX) ? LOCKED : MEASURE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SEARCH;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_total    <= '0;
      h_active   <= '0;
      v_total    <= '0;
      v_active   <= '0;
      pal        <= 1'b0;
      scandouble <= 1'b0;
      frame_done <= 1'b0;
      frame_bad  <= 1'b0;
    end else begin
      frame_done <= frame_done_nxt;
      if (ce_pix) frame_bad <= v_rise ? 1'b0 : (frame_bad | h_sat | v_sat);
      if (frame_done_nxt) begin
        h_total    <= h_per;
        h_active   <= h_act;
        v_total    <= v_per;
        v_active   <= v_act;
        pal        <= pal_new;
        scandouble <= sd_new;
      end
    end
  end

`ifdef SYNC_ANALYZER_LUMA_EN
  logic       pix_active;
  logic [7:0] luma_run;

  assign pix_active = ~HBlank & ~VBlank;

  // The VSync-rise sample opens the new frame's running maximum.
  always_ff @(posedge clk) begin
    if (reset) begin
      luma_run  <= 8'd0;
      luma_peak <= 8'd0;
    end else begin
      if (ce_pix) begin
        if (v_rise)                                 luma_run <= pix_active ? video : 8'd0;
        else if (pix_active && (video > luma_run)) luma_run <= video;
      end
      if (frame_done_nxt) luma_peak <= luma_run;
    end
  end
`else
  logic luma_unused;
  assign luma_unused = ^video;
  assign luma_peak   = 8'd0;
`endif

endmodule

// File: tb/tb_sync_analyzer.sv
// Directed-stream bench: frame_done results are checked by a scoreboard monitor against queued expectations.
module tb_sync_analyzer;

  localparam int SHORT_LEN = 8;
  localparam int SHORT_HB  = 6;
  localparam int LONG_LEN  = 638;
  localparam int LONG_HB   = 529;
  localparam logic [7:0] BASE = 8'h20;
`ifdef SYNC_ANALYZER_LUMA_EN
  localparam logic [7:0] LUMA_STD = BASE;
  localparam logic [7:0] LUMA_PK  = 8'hC4;
`else
  localparam logic [7:0] LUMA_STD = 8'h00;
  localparam logic [7:0] LUMA_PK  = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       reset, ce_pix, HSync, VSync, HBlank, VBlank;
  logic [7:0] video;
  logic [9:0] h_total, h_active, v_total, v_active;
  logic       pal, scandouble, locked, frame_done;
  logic [7:0] luma_peak;

  typedef struct packed {
    logic [9:0] ht, ha, vt, va;
    logic       pal, sd, lk;
    logic [7:0] luma;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   gaps   = 1'b0;

  sync_analyzer dut (
    .clk        (clk),
    .reset      (reset),
    .ce_pix     (ce_pix),
    .HSync      (HSync),
    .VSync      (VSync),
    .HBlank     (HBlank),
    .VBlank     (VBlank),
    .video      (video),
    .h_total    (h_total),
    .h_active   (h_active),
    .v_total    (v_total),
    .v_active   (v_active),
    .pal        (pal),
    .scandouble (scandouble),
    .locked     (locked),
    .frame_done (frame_done),
    .luma_peak  (luma_peak)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic expect_fd(input logic [9:0] ht, ha, vt, va, input logic p, sd, lk,
                           input logic [7:0] luma);
    exp_t e;
    e.ht = ht; e.ha = ha; e.vt = vt; e.va = va;
    e.pal = p; e.sd = sd; e.lk = lk; e.luma = luma;
    exp_q.push_back(e);
  endtask

  // One ce_pix sample, optionally preceded by idle clocks carrying noise on every input.
  task automatic drive(input logic hs, vs, hb, vb, input logic [7:0] vid);
    while (gaps && ($urandom_range(3) == 0)) begin
      @(posedge clk); #1;
      ce_pix = 1'b0;
      HSync  = 1'($urandom);
      VSync  = 1'($urandom);
      HBlank = 1'($urandom);
      VBlank = 1'($urandom);
      video  = 8'($urandom);
    end
    @(posedge clk); #1;
    ce_pix = 1'b1; HSync = hs; VSync = vs; HBlank = hb; VBlank = vb; video = vid;
  endtask

  // Short lines keep frames cheap; the last line of each frame is the full 638-pixel line.
  task automatic frame(input int lines, input int vb_start, input int luma_line);
    for (int l = 0; l < lines; l++) begin
      int len;
      int hb;
      len = (l == lines - 1) ? LONG_LEN : SHORT_LEN;
      hb  = (l == lines - 1) ? LONG_HB  : SHORT_HB;
      for (int p = 0; p < len; p++) begin
        logic [7:0] vid;
        vid = ((p >= hb) || (l >= vb_start)) ? 8'hFF : BASE;
        if ((l == luma_line) && (p == 1)) vid = 8'hC4;
        drive(p < 2, l < 3, p >= hb, l >= vb_start, vid);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_h_total"},    32'(h_total),    32'd0);
    check({tag, "_h_active"},   32'(h_active),   32'd0);
    check({tag, "_v_total"},    32'(v_total),    32'd0);
    check({tag, "_v_active"},   32'(v_active),   32'd0);
    check({tag, "_pal"},        32'(pal),        32'd0);
    check({tag, "_scandouble"}, 32'(scandouble), 32'd0);
    check({tag, "_locked"},     32'(locked),     32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_luma_peak"},  32'(luma_peak),  32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    logic prev_fd;
    prev_fd = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_done) begin
        check("frame_done_pulse", 32'(prev_fd), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_done: got a pulse, want none (h_total %0d v_total %0d)",
                   h_total, v_total);
        end else begin
          e = exp_q.pop_front();
          check("h_total",    32'(h_total),    32'(e.ht));
          check("h_active",   32'(h_active),   32'(e.ha));
          check("v_total",    32'(v_total),    32'(e.vt));
          check("v_active",   32'(v_active),   32'(e.va));
          check("pal",        32'(pal),        32'(e.pal));
          check("scandouble", 32'(scandouble), 32'(e.sd));
          check("locked",     32'(locked),     32'(e.lk));
          check("luma_peak",  32'(luma_peak),  32'(e.luma));
        end
      end
      prev_fd = frame_done;
    end
  end

  initial begin : stimulus
    reset = 1'b1; ce_pix = 1'b0; HSync = 1'b0; VSync = 1'b0;
    HBlank = 1'b0; VBlank = 1'b0; video = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // NTSC with ce_pix gaps; the first VSync rise only starts counting.
    gaps = 1'b1;
    frame(262, 240, -1);
    expect_fd(638, 529, 262, 240, 1'b0, 1'b0, 1'b0, LUMA_STD);
    frame(262, 240, -1);
    expect_fd(638, 529, 262, 240, 1'b0, 1'b0, 1'b0, LUMA_STD);
    frame(262, 240, -1);
    expect_fd(638, 529, 262, 240, 1'b0, 1'b0, 1'b1, LUMA_STD);
    frame(262, 240, -1);

    // Line count switches to 312: lock drops, then relocks two frame_dones later.
    gaps = 1'b0;
    expect_fd(638, 529, 262, 240, 1'b0, 1'b0, 1'b1, LUMA_STD);
    frame(312, 288, -1);
    expect_fd(638, 529, 312, 288, 1'b1, 1'b0, 1'b0, LUMA_STD);
    frame(312, 288, -1);
    expect_fd(638, 529, 312, 288, 1'b1, 1'b0, 1'b0, LUMA_STD);
    frame(312, 288, -1);
    expect_fd(638, 529, 312, 288, 1'b1, 1'b0, 1'b1, LUMA_STD);

    // HSync held low after a coincident HSync/VSync rise: h_cnt reaches 1023 on sample 1023.
    drive(1'b1, 1'b1, 1'b0, 1'b0, BASE);
    for (int i = 1; i <= 1023; i++) drive(1'b0, i < 3, 1'b0, 1'b0, BASE);
    check("locked_before_saturation", 32'(locked), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, BASE);
    check("locked_at_saturation", 32'(locked), 32'd0);
    repeat (80) drive(1'b0, 1'b0, 1'b0, 1'b0, BASE);
    drive(1'b0, 1'b1, 1'b0, 1'b0, BASE);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0, BASE);
    check("hold_h_total", 32'(h_total), 32'd638);
    check("hold_v_total", 32'(v_total), 32'd312);
    check("hold_pal",     32'(pal),     32'd1);
    check("hold_locked",  32'(locked),  32'd0);

    // Partial frame, then reset mid-frame with ce_pix and sync rises present.
    frame(50, 240, -1);
    @(posedge clk); #1;
    reset = 1'b1; ce_pix = 1'b1; HSync = 1'b1; VSync = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b0; ce_pix = 1'b0; HSync = 1'b0; VSync = 1'b0; HBlank = 1'b0; VBlank = 1'b0;

    // PAL scandoubled, ce_pix constant; one 0xC4 active pixel among blanked 0xFF pixels.
    frame(624, 576, 100);
    expect_fd(638, 529, 624, 576, 1'b1, 1'b1, 1'b0, LUMA_PK);
    drive(1'b1, 1'b1, 1'b0, 1'b0, BASE);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0, BASE);
    @(posedge clk); #1;
    ce_pix = 1'b0;
    repeat (5) @(negedge clk);
    check("pending_frame_done", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_analyzer.md
SYNC_ANALYZER -- requirements
Module: sync_analyzer

Interface
REQ-001 SHALL have parameter HW, default 10, horizontal counter width.
REQ-002 SHALL have parameter VW, default 10, vertical counter width.
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, consecutive matching frames required before lock.
REQ-004 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port ce_pix  in  1  pixel enable; all other inputs are sampled only on cycles with ce_pix=1.
REQ-007 SHALL have ports HSync, VSync, HBlank, VBlank  in  1 each  active-high sync and blank inputs.
REQ-008 SHALL have port video  in  8  pixel intensity.
REQ-009 SHALL have port h_total  out  HW  ce_pix count between consecutive HSync rises.
REQ-010 SHALL have port h_active  out  HW  ce_pix count with HBlank=0 within one line.
REQ-011 SHALL have port v_total  out  VW  HSync rises per frame.
REQ-012 SHALL have port v_active  out  VW  HSync rises sampled with VBlank=0 per frame.
REQ-013 SHALL have ports pal, scandouble, locked, frame_done  out  1 each  (frame_done is a one-cycle pulse).
REQ-014 SHALL have port luma_peak  out  8  maximum active-pixel video value of the last frame.

Function
REQ-015 Edge detect SHALL compare each ce_pix sample with the previous ce_pix sample; a rise is 0->1.
REQ-016 h_cnt SHALL load 0 on the HSync-rise sample and increment on every other ce_pix sample; at the next rise, the line length SHALL equal h_cnt+1 (638-pixel line -> 638).
REQ-017 h_cnt and v_cnt SHALL saturate at all-ones; a saturated line or frame SHALL be invalid, and locked SHALL clear the cycle saturation is reached.
REQ-018 A frame SHALL be the HSync rises in the interval (previous VSync rise, current VSync rise]; a coincident HSync+VSync rise SHALL be counted in the ending frame.
REQ-019 On each VSync rise following a complete valid frame: h_total/h_active (last line), v_total, v_active, pal, scandouble and luma_peak SHALL update together, with frame_done=1 on that same cycle, and SHALL hold otherwise.
REQ-020 The first VSync rise after reset SHALL only start counting; there is no output update and no frame_done.
REQ-021 scandouble SHALL be (v_total > 400); pal SHALL be (v_total > 576) if scandouble, else (v_total > 288).
REQ-022 Lock: each frame_done SHALL increment lock_cnt if (h_total, v_total) equal the previous frame's values, else clear lock_cnt and locked; locked SHALL be 1 while lock_cnt >= LOCK_FRAMES.
REQ-023 State machine: SEARCH (awaiting first VSync rise) -> MEASURE (counting) -> LOCKED (lock condition met); a mismatch or saturation SHALL return to MEASURE; reset SHALL return to SEARCH.
REQ-024 Output latency SHALL be one clk after the sampled VSync-rise ce_pix.

Reset
REQ-025 reset SHALL zero all counters and outputs, clear lock_cnt, and enter SEARCH, taking priority over ce_pix; a reset mid-frame SHALL discard the partial measurement.

Configuration
REQ-026 With SYNC_ANALYZER_LUMA_EN defined, luma_peak SHALL track the maximum video value over samples with HBlank=0 and VBlank=0, clearing at each frame start.
REQ-027 Without SYNC_ANALYZER_LUMA_EN, luma_peak SHALL be constant 0, the port SHALL remain present, and no comparator logic SHALL be built.

Structure
REQ-028 Package sync_analyzer_pkg SHALL hold the state enum and the constants 288, 400 and 576.
REQ-029 Sub-module sync_period_counter (edge detect plus saturating counter plus capture) SHALL be instantiated twice, once for horizontal and once for vertical.

Verification
REQ-030 NTSC stream (638 px, HBlank high from px 529; 262 lines, VBlank lines 240-261) -> h_total 638, h_active 529, v_total 262, v_active 240, pal 0, scandouble 0; locked at the 4th VSync rise.
REQ-031 PAL scandoubled stream (624 lines, ce_pix constant 1) -> v_total 624, pal 1, scandouble 1.
REQ-032 Line count switched from 262 to 312 mid-stream -> locked drops at the first 312 frame_done, then relocks two frame_dones later.
REQ-033 HSync held low -> h_cnt saturates at 1023 and locked goes 0; the previous outputs hold.
REQ-034 Reset asserted mid-frame -> next cycle all outputs are 0; no frame_done until the second subsequent VSync rise.
REQ-035 With LUMA_EN: one active pixel 0xC4 plus a blanked pixel 0xFF -> luma_peak 0xC4; without LUMA_EN -> 0.
